// File: rtl/swap_restore.sv
// swap_restore: undoes a conditional two-lane swap and queues the restored pairs in a small FIFO.
// Optional saturating swap counter is enabled by defining SWAP_RESTORE_CNT_EN.
module swap_restore #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_aout,
    input  logic [WIDTH-1:0]         in_bout,
    input  logic                     in_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [7:0]               swap_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_t;

    occ_t state_reg, state_next;
    logic [AW:0] wr_ptr_reg, rd_ptr_reg, level_next;
    logic push, pop;
    logic [WIDTH-1:0] rest_a, rest_b;
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [2*WIDTH-1:0] head;

    // Handshake flags come straight from the occupancy state, so in_ready never sees out_ready.
    assign in_ready  = (state_reg != ST_FULL);
    assign out_valid = (state_reg != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = wr_ptr_reg - rd_ptr_reg;

    assign rest_a = in_s ? in_bout : in_aout;
    assign rest_b = in_s ? in_aout : in_bout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            state_reg  <= ST_EMPTY;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            state_reg <= state_next;
        end
    end

    always_comb begin
        level_next = level;
        state_next = state_reg;
        if (push && !pop)
            level_next = level + (AW+1)'(1);
        else if (pop && !push)
            level_next = level - (AW+1)'(1);
        case (state_reg)
            ST_EMPTY:   if (push) state_next = ST_PARTIAL;
            ST_PARTIAL: begin
                if (level_next == FULL_LVL)
                    state_next = ST_FULL;
                else if (level_next == '0)
                    state_next = ST_EMPTY;
            end
            ST_FULL:    if (pop) state_next = ST_PARTIAL;
            default:    state_next = ST_EMPTY;
        endcase
    end

    // One storage register per FIFO slot; only the slot under the write pointer loads.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [2*WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (rst_n && push && (wr_ptr_reg[AW-1:0] == AW'(gi)))
                    entry_reg <= {rest_a, rest_b};
            end
            assign mem[gi] = entry_reg;
        end
    endgenerate

    // Head is masked while empty so stale slots never leak out (and outputs read 0 after reset).
    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign out_a = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
    assign out_b = out_valid ? head[WIDTH-1:0]       : '0;

`ifdef SWAP_RESTORE_CNT_EN
    logic [7:0] swap_cnt_reg;
    always_ff @(posedge clk) begin
        if (!rst_n)
            swap_cnt_reg <= 8'h00;
        else if (push && in_s && (swap_cnt_reg != 8'hFF))
            swap_cnt_reg <= swap_cnt_reg + 8'h01;
    end
    assign swap_cnt = swap_cnt_reg;
`else
    assign swap_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_swap_restore.sv
// Self-checking bench for swap_restore: truth-table vectors, hand sequences, and random traffic
// compared against a queue-based reference model.
module tb_swap_restore;
    localparam int W = 4;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_s, out_valid, out_ready;
    logic [W-1:0] in_aout, in_bout, out_a, out_b;
    logic [7:0] swap_cnt;
    logic [LW-1:0] level;

    int errors = 0;
    int checks = 0;

    logic [2*W-1:0] mq [$];
    int mcnt = 0;

    typedef struct {
        logic [W-1:0] aout;
        logic [W-1:0] bout;
        logic         s;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } vec_t;
    vec_t tv [8];

    swap_restore #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aout(in_aout), .in_bout(in_bout), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b),
        .swap_cnt(swap_cnt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
`ifdef SWAP_RESTORE_CNT_EN
        return (mcnt > 255) ? 255 : mcnt;
`else
        return 0;
`endif
    endfunction

    // One clock: drive inputs, predict from the model, advance, compare everything.
    task automatic step(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ordy);
        logic do_push, do_pop;
        logic [2*W-1:0] tmp;
        rst_n = r; in_valid = v; in_aout = a; in_bout = b; in_s = s; out_ready = ordy;
        do_push = r && v && (mq.size() != DEPTH);
        do_pop  = r && ordy && (mq.size() != 0);
        @(posedge clk); #1;
        if (!r) begin
            mq.delete();
            mcnt = 0;
            $display("t=%0t reset", $time);
        end else begin
            if (do_pop) begin
                tmp = mq.pop_front();
                $display("t=%0t pop  a=%h b=%h", $time, tmp[2*W-1:W], tmp[W-1:0]);
            end
            if (do_push) begin
                mq.push_back(s ? {b, a} : {a, b});
                if (s) mcnt++;
                $display("t=%0t push aout=%h bout=%h s=%0d", $time, a, b, s);
            end
        end
        chk("level", int'(level), mq.size());
        chk("out_valid", int'(out_valid), int'(mq.size() != 0));
        chk("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
        chk("swap_cnt", int'(swap_cnt), exp_cnt());
        if (mq.size() != 0) begin
            tmp = mq[0];
            chk("out_a", int'(out_a), int'(tmp[2*W-1:W]));
            chk("out_b", int'(out_b), int'(tmp[W-1:0]));
        end
        if (!r) begin
            chk("rst_out_a", int'(out_a), 0);
            chk("rst_out_b", int'(out_b), 0);
        end
    endtask

    task automatic rnd_step(input logic v, input logic ordy);
        step(1'b1, v, W'($urandom), W'($urandom), 1'($urandom), ordy);
    endtask

    initial begin
        tv[0] = '{4'h5, 4'h5, 1'b0, 4'h5, 4'h5};
        tv[1] = '{4'h5, 4'h5, 1'b1, 4'h5, 4'h5};
        tv[2] = '{4'h5, 4'hA, 1'b0, 4'h5, 4'hA};
        tv[3] = '{4'h5, 4'hA, 1'b1, 4'hA, 4'h5};
        tv[4] = '{4'hA, 4'h5, 1'b0, 4'hA, 4'h5};
        tv[5] = '{4'hA, 4'h5, 1'b1, 4'h5, 4'hA};
        tv[6] = '{4'hA, 4'hA, 1'b0, 4'hA, 4'hA};
        tv[7] = '{4'hA, 4'hA, 1'b1, 4'hA, 4'hA};

        // Reset with a pair presented: nothing may be stored.
        step(1'b0, 1'b1, 4'h3, 4'hC, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'h3, 4'hC, 1'b1, 1'b1);

        // Restore truth table, each pair visible one cycle after accept.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, tv[i].aout, tv[i].bout, tv[i].s, 1'b1);
            chk("tt_valid", int'(out_valid), 1);
            chk("tt_a", int'(out_a), int'(tv[i].ea));
            chk("tt_b", int'(out_b), int'(tv[i].eb));
        end
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);

        // Fill and backpressure: fifth pair must be refused.
        for (int i = 0; i < 5; i++) begin
            rnd_step(1'b1, 1'b0);
            if (i == 3) begin
                chk("fill_ready", int'(in_ready), 0);
                chk("fill_level", int'(level), 4);
            end
        end
        for (int i = 0; i < 4; i++) rnd_step(1'b0, 1'b1);
        chk("drain_level", int'(level), 0);

        // Simultaneous push and pop at level 2.
        rnd_step(1'b1, 1'b0);
        rnd_step(1'b1, 1'b0);
        rnd_step(1'b1, 1'b1);
        chk("pp_level", int'(level), 2);
        for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b1);

        // Streaming with random stalls across pointer wraps.
        for (int i = 0; i < 40; i++) rnd_step(1'b1, 1'($urandom));
        for (int i = 0; i < 5; i++) rnd_step(1'b0, 1'b1);

        // Counter saturation from a clean count.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 305; i++) step(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1);
`ifdef SWAP_RESTORE_CNT_EN
        chk("sat_cnt", int'(swap_cnt), 255);
`else
        chk("sat_cnt", int'(swap_cnt), 0);
`endif

        // Fully random traffic.
        for (int i = 0; i < 500; i++) rnd_step(1'($urandom), 1'($urandom));

        // Mid-operation reset at level 3.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rnd_step(1'b1, 1'b0);
        chk("pre_rst_level", int'(level), 3);
        step(1'b0, 1'b1, 4'h9, 4'h6, 1'b1, 1'b1);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_cnt", int'(swap_cnt), 0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("post_rst_level", int'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
